selfcomp_leak_monitor: RTL and testbench
========================================

SELFCOMP_LEAK_MONITOR -- requirements
Module: selfcomp_leak_monitor

Interface
REQ-001 Parameter DATA_W, default 128, SHALL set the result width.
REQ-002 Parameter CNT_W, default 8, SHALL set the skew and watchdog counter width.
REQ-003 Parameter TIMEOUT, default 200, SHALL set the cycle limit for both watchdogs; legal range 1 to 2^CNT_W-1.
REQ-004 clock  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low; reset==0 SHALL force reset state immediately, independent of clock.
REQ-006 start  in  1  one-cycle pulse marking issue of a transaction to both SE copies.
REQ-007 validOne  in  1  result-valid from SE copy one.
REQ-008 resultOne  in  DATA_W  result from SE copy one.
REQ-009 validTwo  in  1  result-valid from SE copy two.
REQ-010 resultTwo  in  DATA_W  result from SE copy two.
REQ-011 out_ready  out  1  shared result-ready driven to both SE copies.
REQ-012 busy  out  1  high whenever the state is not IDLE.
REQ-013 skew  out  CNT_W  cycles between the two result handshakes.
REQ-014 timingLeak  out  1  sticky: handshake cycles differed.
REQ-015 resultMismatch  out  1  sticky: captured results differed.
REQ-016 timeout  out  1  sticky: a watchdog expired.
REQ-017 timingLeakDone  out  1  one-cycle pulse: verdict valid.

Function
REQ-018 States SHALL be IDLE, WAIT_BOTH, WAIT_TWO (one captured), WAIT_ONE (two captured) and DONE.
REQ-019 out_ready SHALL be 1 in WAIT_BOTH, WAIT_ONE and WAIT_TWO, and 0 in IDLE and DONE.
REQ-020 A handshake on a side SHALL be valid AND out_ready at a rising edge; the result SHALL be captured into that side's register on that edge.
REQ-021 In IDLE, start==1 SHALL go to WAIT_BOTH; it SHALL clear skew, timingLeak, resultMismatch and timeout, and zero the watchdog counter.
REQ-022 A start asserted outside IDLE SHALL be ignored with no effect.
REQ-023 In WAIT_BOTH with both handshakes in the same cycle, the FSM SHALL capture both, set skew=0, leave timingLeak=0 and go to DONE.
REQ-024 In WAIT_BOTH with only validOne, the FSM SHALL capture one, load skew=1 and go to WAIT_TWO; only validTwo SHALL mirror this into WAIT_ONE.
REQ-025 In WAIT_ONE and WAIT_TWO, skew SHALL increment by 1 each cycle without the missing handshake, saturating at 2^CNT_W-1.
REQ-026 A handshake from the already-captured side in WAIT_ONE or WAIT_TWO SHALL be ignored, and its register SHALL NOT be overwritten.
REQ-027 When the missing handshake occurs, the FSM SHALL capture it, set timingLeak=1, hold skew and go to DONE.
REQ-028 skew SHALL equal the cycle index of the later handshake minus the cycle index of the earlier one.
REQ-029 On entering DONE with both results captured, resultMismatch SHALL be set if resultOne_reg != resultTwo_reg, compared over the full DATA_W.
REQ-030 Watchdog A: in WAIT_BOTH the counter SHALL increment each cycle; reaching TIMEOUT with no handshake SHALL set timeout=1, leave timingLeak=0 and go to DONE.
REQ-031 Watchdog B: in WAIT_ONE or WAIT_TWO, skew reaching TIMEOUT SHALL set timeout=1 and timingLeak=1 and go to DONE; resultMismatch SHALL NOT be evaluated.
REQ-032 If a handshake and watchdog expiry fall in the same cycle, the handshake SHALL win.
REQ-033 DONE SHALL last exactly one cycle, with timingLeakDone=1 in that cycle, then return to IDLE.
REQ-034 Verdict outputs SHALL hold their values in IDLE until the next accepted start.
REQ-035 A start in the DONE cycle SHALL be ignored; the earliest accepted start SHALL be the first IDLE cycle.

Reset
REQ-036 While reset==0, the state SHALL be IDLE, and out_ready, busy, timingLeak, resultMismatch, timeout and timingLeakDone SHALL be 0.
REQ-037 While reset==0, skew, the watchdog counter and both result registers SHALL be 0.
REQ-038 Reset asserted mid-transaction SHALL abandon it with no timingLeakDone pulse.
REQ-039 After reset deasserts, the first accepted start SHALL be on the first rising edge.

Verification
REQ-040 Start, then validOne=validTwo=1 two cycles later with equal results 0x5A -> next cycle timingLeakDone=1, skew=0, timingLeak=0, resultMismatch=0.
REQ-041 Start, then validOne at cycle 3 and validTwo at cycle 7 with equal results -> timingLeakDone one cycle after cycle 7, skew=4, timingLeak=1, resultMismatch=0.
REQ-042 Start, then both valid in the same cycle with resultOne=0x1, resultTwo=0x3 -> skew=0, timingLeak=0, resultMismatch=1.
REQ-043 Start with TIMEOUT=10 and no valids -> timingLeakDone after 10 WAIT_BOTH cycles, timeout=1, timingLeak=0; then only validOne with TIMEOUT=10 -> timeout=1, timingLeak=1, skew=10.
REQ-044 In WAIT_TWO, pulse reset low asynchronously mid-cycle -> outputs 0 immediately, no timingLeakDone; a new start then completes normally.
REQ-045 A start pulse during WAIT_BOTH and during DONE -> ignored; skew and verdict flags unchanged.

Source files
------------

// File: rtl/selfcomp_leak_monitor.sv
// selfcomp_leak_monitor: watches two redundant SE copies issued by the same
// start pulse and reports whether their result handshakes landed on
// different cycles (timing leak), whether the results differed, and whether
// either copy stalled past the watchdog limit.
module selfcomp_leak_monitor #(
   parameter int DATA_W  = 128,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 200
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              validOne,
   input  logic [DATA_W-1:0] resultOne,
   input  logic              validTwo,
   input  logic [DATA_W-1:0] resultTwo,
   output logic              out_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  skew,
   output logic              timingLeak,
   output logic              resultMismatch,
   output logic              timeout,
   output logic              timingLeakDone
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_BOTH, S_WAIT_TWO, S_WAIT_ONE, S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] C_TO  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] C_MAX = '1;
   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

   state_t              r_state;
   logic                r_out_ready;
   logic                r_busy;
   logic [CNT_W-1:0]    r_skew;
   logic [CNT_W-1:0]    r_wdog;
   logic                r_leak;
   logic                r_mism;
   logic                r_tmo;
   logic                r_done;
   logic [DATA_W-1:0]   r_res_one;
   logic [DATA_W-1:0]   r_res_two;

   logic                w_hs_one;
   logic                w_hs_two;
   logic [CNT_W-1:0]    w_skew_inc;
   logic [CNT_W-1:0]    w_wdog_inc;

   // A handshake needs out_ready, which is only high in the wait states.
   assign w_hs_one   = validOne & r_out_ready;
   assign w_hs_two   = validTwo & r_out_ready;
   // Both counters saturate rather than wrap.
   assign w_skew_inc = (r_skew == C_MAX) ? r_skew : r_skew + C_ONE;
   assign w_wdog_inc = (r_wdog == C_MAX) ? r_wdog : r_wdog + C_ONE;

   // Control FSM; every output is a register updated alongside the state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_out_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_skew      <= '0;
         r_wdog      <= '0;
         r_leak      <= 1'b0;
         r_mism      <= 1'b0;
         r_tmo       <= 1'b0;
         r_done      <= 1'b0;
         r_res_one   <= '0;
         r_res_two   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state     <= S_WAIT_BOTH;
                  r_out_ready <= 1'b1;
                  r_busy      <= 1'b1;
                  r_skew      <= '0;
                  r_wdog      <= '0;
                  r_leak      <= 1'b0;
                  r_mism      <= 1'b0;
                  r_tmo       <= 1'b0;
               end
            end
            S_WAIT_BOTH: begin
               r_wdog <= w_wdog_inc;
               if (w_hs_one && w_hs_two) begin
                  r_res_one   <= resultOne;
                  r_res_two   <= resultTwo;
                  r_skew      <= '0;
                  r_mism      <= (resultOne != resultTwo);
                  r_state     <= S_DONE;
                  r_out_ready <= 1'b0;
                  r_done      <= 1'b1;
               end else if (w_hs_one) begin
                  r_res_one <= resultOne;
                  r_skew    <= C_ONE;
                  r_state   <= S_WAIT_TWO;
               end else if (w_hs_two) begin
                  r_res_two <= resultTwo;
                  r_skew    <= C_ONE;
                  r_state   <= S_WAIT_ONE;
               end else if (w_wdog_inc >= C_TO) begin
                  // Neither copy answered: no leak verdict, no compare.
                  r_tmo       <= 1'b1;
                  r_state     <= S_DONE;
                  r_out_ready <= 1'b0;
                  r_done      <= 1'b1;
               end
            end
            S_WAIT_TWO: begin
               // Repeat handshakes from copy one are ignored here.
               if (w_hs_two) begin
                  r_res_two   <= resultTwo;
                  r_leak      <= 1'b1;
                  r_mism      <= (r_res_one != resultTwo);
                  r_state     <= S_DONE;
                  r_out_ready <= 1'b0;
                  r_done      <= 1'b1;
               end else begin
                  r_skew <= w_skew_inc;
                  if (w_skew_inc >= C_TO) begin
                     r_tmo       <= 1'b1;
                     r_leak      <= 1'b1;
                     r_state     <= S_DONE;
                     r_out_ready <= 1'b0;
                     r_done      <= 1'b1;
                  end
               end
            end
            S_WAIT_ONE: begin
               // Repeat handshakes from copy two are ignored here.
               if (w_hs_one) begin
                  r_res_one   <= resultOne;
                  r_leak      <= 1'b1;
                  r_mism      <= (resultOne != r_res_two);
                  r_state     <= S_DONE;
                  r_out_ready <= 1'b0;
                  r_done      <= 1'b1;
               end else begin
                  r_skew <= w_skew_inc;
                  if (w_skew_inc >= C_TO) begin
                     r_tmo       <= 1'b1;
                     r_leak      <= 1'b1;
                     r_state     <= S_DONE;
                     r_out_ready <= 1'b0;
                     r_done      <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               // Single verdict cycle; a start here is dropped.
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_ready <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign out_ready      = r_out_ready;
   assign busy           = r_busy;
   assign skew           = r_skew;
   assign timingLeak     = r_leak;
   assign resultMismatch = r_mism;
   assign timeout        = r_tmo;
   assign timingLeakDone = r_done;

endmodule

// File: tb/tb_selfcomp_leak_monitor.sv
// Scoreboard bench for selfcomp_leak_monitor: each transaction pushes its
// predicted verdict (cycle, skew, flags) and the done-pulse monitor pops it.
module tb_selfcomp_leak_monitor;

   localparam int DW = 128;
   localparam int CW = 8;
   localparam int TO = 10;
   localparam int NONE = 1000;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic          validOne;
   logic [DW-1:0] resultOne;
   logic          validTwo;
   logic [DW-1:0] resultTwo;
   logic          out_ready;
   logic          busy;
   logic [CW-1:0] skew;
   logic          timingLeak;
   logic          resultMismatch;
   logic          timeout;
   logic          timingLeakDone;

   typedef struct {
      int            done_cyc;
      logic [CW-1:0] skew;
      logic          leak;
      logic          mism;
      logic          tmo;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   selfcomp_leak_monitor #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT(TO)) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .validOne       (validOne),
      .resultOne      (resultOne),
      .validTwo       (validTwo),
      .resultTwo      (resultTwo),
      .out_ready      (out_ready),
      .busy           (busy),
      .skew           (skew),
      .timingLeak     (timingLeak),
      .resultMismatch (resultMismatch),
      .timeout        (timeout),
      .timingLeakDone (timingLeakDone)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Done-pulse monitor: every pulse must match the oldest prediction.
   always @(negedge clock) begin
      if (timingLeakDone === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("done_unexpected", timingLeakDone, 1'b0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("done_cyc", cyc, e.done_cyc);
            chk("skew", skew, e.skew);
            chk("timingLeak", timingLeak, e.leak);
            chk("resultMismatch", resultMismatch, e.mism);
            chk("timeout", timeout, e.tmo);
         end
      end
   end

   // Reference verdict from handshake offsets (0 = copy never answers).
   task automatic model(input int d1, input int d2, input logic [DW-1:0] r1,
                        input logic [DW-1:0] r2, output int off, output exp_t e);
      int e1, e2, lo, hi;
      e1 = (d1 == 0) ? NONE : d1;
      e2 = (d2 == 0) ? NONE : d2;
      lo = (e1 < e2) ? e1 : e2;
      hi = (e1 < e2) ? e2 : e1;
      e.done_cyc = 0;
      if (lo > TO) begin
         off = TO; e.skew = '0; e.leak = 0; e.mism = 0; e.tmo = 1;
      end else if (e1 == e2) begin
         off = lo; e.skew = '0; e.leak = 0; e.mism = (r1 != r2); e.tmo = 0;
      end else if (hi - lo <= TO - 1) begin
         off = hi; e.skew = CW'(hi - lo); e.leak = 1; e.mism = (r1 != r2); e.tmo = 0;
      end else begin
         off = lo + TO - 1; e.skew = CW'(TO); e.leak = 1; e.mism = 0; e.tmo = 1;
      end
   endtask

   // Called just after a rising edge with the DUT idle.
   task automatic run_txn(input int d1, input int d2, input int dup1,
                          input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                          input bit st_mid, input bit st_done, input bit rel);
      exp_t e;
      int   off;
      model(d1, d2, r1, r2, off, e);
      start = 1'b1;
      if (rel) begin
         @(negedge clock);
         reset = 1'b1;
      end
      e.done_cyc = cyc + 1 + off;
      sb_q.push_back(e);
      @(posedge clock); #1;
      start = 1'b0;
      for (int k = 1; k <= off; k++) begin
         start     = st_mid && (k == 1);
         validOne  = (k == d1) || (k == dup1);
         resultOne = (k == d1) ? r1 : {4{$urandom}};
         validTwo  = (k == d2);
         resultTwo = (k == d2) ? r2 : {4{$urandom}};
         @(negedge clock);
         chk("out_ready_wait", out_ready, 1'b1);
         @(posedge clock); #1;
      end
      validOne = 1'b0;
      validTwo = 1'b0;
      start    = st_done;
      @(posedge clock); #1;
      start = 1'b0;
      @(negedge clock);
      chk("busy_after", busy, 1'b0);
      chk("hold_skew", skew, e.skew);
      chk("hold_leak", timingLeak, e.leak);
      chk("sb_drained", sb_q.size(), 0);
      @(posedge clock); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [DW-1:0] a, b, msb;
      reset = 1'b0; start = 1'b0;
      validOne = 1'b0; validTwo = 1'b0;
      resultOne = '0; resultTwo = '0;
      repeat (3) @(negedge clock);
      chk("rst_busy", busy, 1'b0);
      chk("rst_out_ready", out_ready, 1'b0);
      chk("rst_skew", skew, '0);
      chk("rst_leak", timingLeak, 1'b0);
      chk("rst_mism", resultMismatch, 1'b0);
      chk("rst_tmo", timeout, 1'b0);
      chk("rst_done", timingLeakDone, 1'b0);
      reset = 1'b1;
      @(posedge clock); #1;

      a   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      msb = '0; msb[DW-1] = 1'b1;
      b   = a ^ msb;
      run_txn(2, 2, 0, 128'h5A, 128'h5A, 0, 0, 0);
      run_txn(3, 7, 0, 128'h5A, 128'h5A, 0, 0, 0);
      run_txn(2, 2, 0, 128'h1, 128'h3, 0, 0, 0);
      run_txn(6, 2, 0, 128'hA, 128'hB, 0, 0, 0);
      run_txn(0, 0, 0, '0, '0, 1, 0, 0);
      run_txn(2, 0, 0, 128'h7, '0, 0, 0, 0);
      run_txn(10, 10, 0, a, a, 0, 0, 0);
      run_txn(1, 10, 0, a, a, 0, 0, 0);
      run_txn(1, 11, 0, a, a, 0, 0, 0);
      run_txn(1, 5, 3, a, a, 0, 0, 0);
      run_txn(2, 2, 0, a, b, 0, 0, 0);
      run_txn(4, 4, 0, 128'h5A, 128'h5A, 1, 1, 0);

      // Asynchronous reset while waiting on copy two.
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; validOne = 1'b1; resultOne = 128'h99;
      @(posedge clock); #1;
      validOne = 1'b0;
      #2;
      chk("pre_rst_skew", skew, 8'd1);
      chk("pre_rst_busy", busy, 1'b1);
      reset = 1'b0;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_out_ready", out_ready, 1'b0);
      chk("arst_skew", skew, '0);
      chk("arst_leak", timingLeak, 1'b0);
      @(posedge clock); #1;
      run_txn(2, 5, 0, 128'h42, 128'h43, 0, 0, 1);

      for (int i = 0; i < 8; i++) begin
         int d1, d2;
         d1 = $urandom_range(0, 12);
         d2 = $urandom_range(0, 12);
         a  = {4{$urandom}};
         b  = ($urandom_range(0, 1) == 1) ? a : {4{$urandom}};
         run_txn(d1, d2, 0, a, b, 0, 0, 0);
      end

      repeat (3) @(posedge clock);
      chk("sb_final", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
